// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [1:0] {
      UART_RX_IDLE,
      UART_RX_START,
      UART_RX_DATA,
      UART_RX_STOP
   } uart_rx_state_t;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_BIT_IDX_W    = $clog2(UART_DATA_BITS);
   localparam int UART_CLKS_PER_BIT = 435;

endpackage

// File: rtl/uart_rx_sync.sv
// Optional 2-flop input synchronizer for the serial line (enabled by UART_RX_SYNC_EN).
// Flops reset to 1 so an idle line never looks like a start bit after reset.
module uart_rx_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_line,
   output logic o_line
);

`ifdef UART_RX_SYNC_EN
   logic [1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_sync <= 2'b11;
      else          r_sync <= {r_sync[0], i_line};
   end

   assign o_line = r_sync[1];
`else
   logic w_unused;

   // Caller guarantees the line is already synchronous to i_clk.
   assign w_unused = i_clk ^ i_rst_n;
   assign o_line   = i_line;
`endif

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, LSB first, oversampled by clk; reports frame-decode duration.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer in front of TxD.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      TxD,
   output logic                      DataComplete,
   output logic [UART_DATA_BITS-1:0] UartData,
   output logic [31:0]               EndCount,
   output logic [1:0]                o_dbg_state
);

   localparam logic [31:0]               HALF     = 32'(CLKS_PER_BIT / 2);
   localparam logic [31:0]               CPB      = 32'(CLKS_PER_BIT);
   localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

   uart_rx_state_t              r_state, w_state_nxt;
   logic [31:0]                 r_count;
   logic [31:0]                 r_timer;
   logic [UART_BIT_IDX_W-1:0]   r_bit_idx;
   logic [UART_DATA_BITS-1:0]   r_shift;
   logic                        r_frame_err;
   logic                        r_data_complete;
   logic [UART_DATA_BITS-1:0]   r_uart_data;
   logic [31:0]                 r_end_count;

   logic w_line;
   logic w_cnt_clr, w_timer_rst, w_sample, w_commit, w_err_set, w_err_clr;

   uart_rx_sync u_sync (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_line  (TxD),
      .o_line  (w_line)
   );

   always_ff @(posedge clk) begin
      if (!reset) r_state <= UART_RX_IDLE;
      else        r_state <= w_state_nxt;
   end

   // r_count equals the number of edges since start detection, so it is the
   // absolute frame position; r_timer measures each bit period from the last sample.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_timer_rst = 1'b0;
      w_sample    = 1'b0;
      w_commit    = 1'b0;
      w_err_set   = 1'b0;
      w_err_clr   = 1'b0;
      case (r_state)
         UART_RX_IDLE: begin
            if (!w_line) begin
               w_state_nxt = UART_RX_START;
               w_cnt_clr   = 1'b1;
            end
         end
         UART_RX_START: begin
            if (r_count == HALF) begin
               if (w_line) begin
                  w_state_nxt = UART_RX_IDLE;
               end else begin
                  w_state_nxt = UART_RX_DATA;
                  w_timer_rst = 1'b1;
               end
            end
         end
         UART_RX_DATA: begin
            if (r_timer == CPB) begin
               w_sample    = 1'b1;
               w_timer_rst = 1'b1;
               if (r_bit_idx == LAST_BIT) w_state_nxt = UART_RX_STOP;
            end
         end
         UART_RX_STOP: begin
            if (r_frame_err) begin
               if (w_line) begin
                  w_state_nxt = UART_RX_IDLE;
                  w_err_clr   = 1'b1;
               end
            end else if (r_timer == CPB) begin
               if (w_line) begin
                  w_state_nxt = UART_RX_IDLE;
                  w_commit    = 1'b1;
               end else begin
                  w_err_set   = 1'b1;
               end
            end
         end
         default: w_state_nxt = UART_RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count         <= '0;
         r_timer         <= '0;
         r_bit_idx       <= '0;
         r_shift         <= '0;
         r_frame_err     <= 1'b0;
         r_data_complete <= 1'b0;
         r_uart_data     <= '0;
         r_end_count     <= '0;
      end else begin
         r_data_complete <= w_commit;
         r_count         <= w_cnt_clr   ? 32'd1 : r_count + 32'd1;
         r_timer         <= w_timer_rst ? 32'd1 : r_timer + 32'd1;
         if (w_cnt_clr)     r_bit_idx <= '0;
         else if (w_sample) r_bit_idx <= r_bit_idx + 1'b1;
         if (w_sample) r_shift[r_bit_idx] <= w_line;
         if (w_err_set)      r_frame_err <= 1'b1;
         else if (w_err_clr) r_frame_err <= 1'b0;
         // Only a frame with a good stop bit reaches the outputs.
         if (w_commit) begin
            r_uart_data <= r_shift;
            r_end_count <= r_count;
         end
      end
   end

   assign DataComplete = r_data_complete;
   assign UartData     = r_uart_data;
   assign EndCount     = r_end_count;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: two instances (435 and 16 clocks/bit)
// compared every cycle against a frame-level timing model.
module tb_uart_rx_core;

   localparam int CPB0 = 435;
   localparam int CPB1 = 16;
`ifdef UART_RX_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b0;
   logic        line   [2];
   logic        dc     [2];
   logic [7:0]  data   [2];
   logic [31:0] endc   [2];
   logic [1:0]  st     [2];

   uart_rx_core #(.CLKS_PER_BIT(CPB0)) dut (
      .clk          (clk),
      .reset        (reset),
      .TxD          (line[0]),
      .DataComplete (dc[0]),
      .UartData     (data[0]),
      .EndCount     (endc[0]),
      .o_dbg_state  (st[0])
   );

   uart_rx_core #(.CLKS_PER_BIT(CPB1)) dut16 (
      .clk          (clk),
      .reset        (reset),
      .TxD          (line[1]),
      .DataComplete (dc[1]),
      .UartData     (data[1]),
      .EndCount     (endc[1]),
      .o_dbg_state  (st[1])
   );

   int   cyc   = 0;
   logic rst_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   // scoreboard: {expected pulse cycle, byte}
   logic [39:0] exp_q0[$];
   logic [39:0] exp_q1[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          pulses [2] = '{0, 0};
   logic [7:0]  m_data [2] = '{8'h00, 8'h00};
   logic [31:0] m_end  [2] = '{32'd0, 32'd0};
   logic [39:0] cmp_head;
   bit          cmp_due;

   function automatic int end_cnt(input int cpb);
      return cpb / 2 + 9 * cpb;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // compare process: every cycle after reset, for both instances
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_q) begin
            m_data[k] = 8'h00;
            m_end[k]  = 32'd0;
            if (k == 0) exp_q0.delete();
            else        exp_q1.delete();
         end else begin
            cmp_due = 1'b0;
            if (k == 0 && exp_q0.size() > 0 && exp_q0[0][39:8] == 32'(cyc)) begin
               cmp_due  = 1'b1;
               cmp_head = exp_q0.pop_front();
            end
            if (k == 1 && exp_q1.size() > 0 && exp_q1[0][39:8] == 32'(cyc)) begin
               cmp_due  = 1'b1;
               cmp_head = exp_q1.pop_front();
            end
            chk($sformatf("pulse[%0d]", k), 32'(dc[k]), 32'(cmp_due));
            if (dc[k]) pulses[k]++;
            if (cmp_due) begin
               m_data[k] = cmp_head[7:0];
               m_end[k]  = 32'(end_cnt(k == 0 ? CPB0 : CPB1));
            end
            chk($sformatf("UartData[%0d]", k), 32'(data[k]), 32'(m_data[k]));
            chk($sformatf("EndCount[%0d]", k), endc[k], m_end[k]);
         end
      end
   end

   // driver: called at a falling edge, returns at a falling edge
   task automatic send_frame(input int k, input logic [7:0] d, input logic stop_b, input bit ok);
      logic [9:0]  bits;
      logic [39:0] e;
      int          cpb;
      bits = {stop_b, d, 1'b0};
      cpb  = (k == 0) ? CPB0 : CPB1;
      if (ok) begin
         e = {32'(cyc + 1 + cpb / 2 + 9 * cpb + SYNC_LAT), d};
         if (k == 0) exp_q0.push_back(e);
         else        exp_q1.push_back(e);
      end
      for (int i = 0; i < 10; i++) begin
         line[k] = bits[i];
         repeat (cpb) @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int          p0;
   int          gap;
   logic [7:0]  rnd;

   initial begin
      line[0] = 1'b1;
      line[1] = 1'b1;
      reset   = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset DataComplete", 32'(dc[0]), 32'd0);
      chk("reset UartData", 32'(data[0]), 32'h00);
      chk("reset EndCount", endc[0], 32'd0);
      reset = 1'b1;

      p0 = pulses[0];
      idle(10000);
      chk("idle pulses", 32'(pulses[0] - p0), 32'd0);

      // four back-to-back frames of 32'hA1B2C3D4, LSB byte first
      p0 = pulses[0];
      send_frame(0, 8'hD4, 1'b1, 1'b1);
      send_frame(0, 8'hC3, 1'b1, 1'b1);
      send_frame(0, 8'hB2, 1'b1, 1'b1);
      send_frame(0, 8'hA1, 1'b1, 1'b1);
      idle(5);
      chk("b2b pulses", 32'(pulses[0] - p0), 32'd4);
      chk("b2b last byte", 32'(data[0]), 32'hA1);
      chk("b2b EndCount", endc[0], 32'd4132);

      // glitch shorter than half a bit
      p0 = pulses[0];
      line[0] = 1'b0;
      idle(100);
      line[0] = 1'b1;
      idle(1000);
      chk("glitch pulses", 32'(pulses[0] - p0), 32'd0);
      send_frame(0, 8'h55, 1'b1, 1'b1);
      idle(5);
      chk("after glitch byte", 32'(data[0]), 32'h55);

      // framing error, line stuck low afterwards
      p0 = pulses[0];
      send_frame(0, 8'h3C, 1'b0, 1'b0);
      idle(1000);
      line[0] = 1'b1;
      idle(1000);
      chk("framing pulses", 32'(pulses[0] - p0), 32'd0);
      chk("framing keeps byte", 32'(data[0]), 32'h55);
      send_frame(0, 8'h81, 1'b1, 1'b1);
      idle(5);
      chk("after framing byte", 32'(data[0]), 32'h81);

      // reset during data bit 4 of 0xFF
      line[0] = 1'b0;
      idle(CPB0);
      line[0] = 1'b1;
      idle(4 * CPB0 + 200);
      reset = 1'b0;
      idle(5);
      chk("midreset DataComplete", 32'(dc[0]), 32'd0);
      chk("midreset UartData", 32'(data[0]), 32'h00);
      chk("midreset EndCount", endc[0], 32'd0);
      reset = 1'b1;
      idle(1000);
      p0 = pulses[0];
      send_frame(0, 8'h12, 1'b1, 1'b1);
      idle(5);
      chk("after reset byte", 32'(data[0]), 32'h12);
      chk("after reset pulses", 32'(pulses[0] - p0), 32'd1);

      // random bytes with random (often zero) idle gaps
      for (int n = 0; n < 4; n++) begin
         rnd = 8'($urandom_range(0, 255));
         gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
         send_frame(0, rnd, 1'b1, 1'b1);
         idle(gap);
      end

      // short bit period instance
      p0 = pulses[1];
      send_frame(1, 8'hA5, 1'b1, 1'b1);
      idle(5);
      chk("cpb16 byte", 32'(data[1]), 32'hA5);
      chk("cpb16 EndCount", endc[1], 32'd152);
      chk("cpb16 pulses", 32'(pulses[1] - p0), 32'd1);

      idle(20);
      chk("queue drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
